// File: rtl/fifo_bus_pkg.sv
// Shared types for the FIFO bus master: FSM states and remembered bus direction.
package fifo_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TURN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_WR   = 2'd1,
        DIR_RD   = 2'd2
    } dir_t;

    function automatic dir_t cmd_dir(input logic rw);
        return rw ? DIR_WR : DIR_RD;
    endfunction

endpackage

// File: rtl/cmd_queue.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module cmd_queue #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/fifo_bus_master.sv
// Initiator of the shared FIFO data bus: queues commands, runs bus cycles, and
// inserts one TURN cycle whenever the bus direction flips.
module fifo_bus_master
    import fifo_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  en_write,
    output logic                  en_read,
    inout  wire  [DATA_WIDTH-1:0] databus,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy
);

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH:0]   w_head;
    dir_t                  w_head_dir;
    state_t                w_next_state;
    logic                  w_en_write_d;
    logic                  w_en_read_d;

    state_t                r_state;
    dir_t                  r_dir;
    logic                  r_en_write;
    logic                  r_en_read;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && cmd_ready;

    cmd_queue #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_cmd_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({cmd_rw, cmd_wdata}),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    assign w_head_dir = cmd_dir(w_head[DATA_WIDTH]);

    // Strobes and bus enable are registered alongside the state so no cmd_* path reaches the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_dir      <= DIR_NONE;
            r_en_write <= 1'b0;
            r_en_read  <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_next_state;
            r_en_write <= w_en_write_d;
            r_en_read  <= w_en_read_d;
            if (w_pop) begin
                r_dir   <= w_head_dir;
                r_wdata <= w_head[DATA_WIDTH-1:0];
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = IDLE;
        if (!w_empty) begin
            if (r_state == TURN || r_dir == DIR_NONE || w_head_dir == r_dir) begin
                w_next_state = w_head[DATA_WIDTH] ? WRITE : READ;
            end else begin
                w_next_state = TURN;
            end
        end
    end

    always_comb begin
        w_en_write_d = (w_next_state == WRITE);
        w_en_read_d  = (w_next_state == READ);
        w_pop        = w_en_write_d || w_en_read_d;
    end

    // The bus is sampled at the edge that closes a READ cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= r_en_read;
            if (r_en_read) r_rsp_data <= databus;
        end
    end

    assign databus   = r_en_write ? r_wdata : {DATA_WIDTH{1'bz}};
    assign en_write  = r_en_write;
    assign en_read   = r_en_read;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_fifo_bus_master.sv
// Bench for fifo_bus_master: a bus-cycle schedule model predicts strobes, bus,
// responses and queue state each cycle; directed steps then randomized traffic.
module tb_fifo_bus_master;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int MAXC  = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_rw = 1'b0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [DW-1:0] resp_val = '0;
    logic          cmd_ready;
    logic          en_write;
    logic          en_read;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy;
    wire  [DW-1:0] databus;

    fifo_bus_master #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .en_write  (en_write),
        .en_read   (en_read),
        .databus   (databus),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Responder drives only while the master requests a read; otherwise the bus floats high.
    assign databus = en_read ? resp_val : {DW{1'bz}};
    for (genvar i = 0; i < DW; i++) begin : g_pull
        pullup (databus[i]);
    end

    always #5 clk = ~clk;

    // Model: each cycle is IDLE(0), WRITE(1), READ(2) or TURN(3).
    int          sched   [MAXC];
    logic [DW-1:0] wdv   [MAXC];
    logic [DW-1:0] rdv   [MAXC];
    int          push_at [MAXC];
    int          pop_at  [MAXC];
    int          cur;
    int          occ;
    int          last_t;
    int          last_dir;
    logic [DW-1:0] exp_rsp;
    int          checks = 0;
    int          errors = 0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cur, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cur, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < MAXC; i++) begin
            sched[i] = 0; wdv[i] = '0; rdv[i] = '0; push_at[i] = 0; pop_at[i] = 0;
        end
        occ = 0; last_t = -1; last_dir = 0; exp_rsp = '0;
    endtask

    // An accepted command issues one cycle after it is visible and after the previous
    // bus cycle, plus one TURN cycle if it reverses the last direction used.
    task automatic schedule(input int c, input logic rw, input logic [DW-1:0] wd);
        int dir;
        int t;
        dir = rw ? 1 : 2;
        t = (c + 1 > last_t + 1) ? c + 1 : last_t + 1;
        if (last_dir != 0 && dir != last_dir) begin
            sched[t] = 3;
            t++;
        end
        sched[t] = rw ? 1 : 2;
        wdv[t] = wd;
        push_at[c]++;
        pop_at[t]++;
        last_t = t;
        last_dir = dir;
    endtask

    task automatic check_cycle(input int k);
        int   kind;
        logic exp_rv;
        logic [DW-1:0] exp_bus;
        kind = sched[k];
        exp_bus = (kind == 1) ? wdv[k] : (kind == 2) ? rdv[k] : {DW{1'b1}};
        exp_rv = (k > 0) && (sched[k-1] == 2);
        if (exp_rv) exp_rsp = rdv[k-1];
        check_bit("en_write", en_write, kind == 1);
        check_bit("en_read", en_read, kind == 2);
        check_byte("databus", databus, exp_bus);
        check_bit("cmd_ready", cmd_ready, occ < DEPTH);
        check_bit("busy", busy, (occ > 0) || (kind != 0));
        check_bit("rsp_valid", rsp_valid, exp_rv);
        check_byte("rsp_data", rsp_data, exp_rsp);
    endtask

    // One clock: offer a command for the next edge, then check the cycle that follows it.
    task automatic step(input logic v, input logic rw, input logic [DW-1:0] wd, input logic [DW-1:0] rv);
        cmd_valid = v;
        cmd_rw    = rw;
        cmd_wdata = wd;
        if (v && occ < DEPTH) schedule(cur + 1, rw, wd);
        @(posedge clk);
        cur++;
        occ += push_at[cur] - pop_at[cur];
        #1;
        resp_val  = rv;
        rdv[cur]  = rv;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_cycle(cur);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, DW'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check_bit("rst_en_write", en_write, 1'b0);
        check_bit("rst_en_read", en_read, 1'b0);
        check_byte("rst_databus", databus, {DW{1'b1}});
        check_bit("rst_rsp_valid", rsp_valid, 1'b0);
        check_byte("rst_rsp_data", rsp_data, '0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_cmd_ready", cmd_ready, 1'b1);
        repeat (2) begin
            @(posedge clk);
            cur++;
        end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    initial begin
        cur = 0;
        model_clear();
        #2;
        do_reset();

        // Single write of 0xA5.
        step(1'b1, 1'b1, 8'hA5, 8'h00);
        idle(4);

        // Single read, then four back-to-back reads, responder returning 0x3C.
        do_reset();
        step(1'b1, 1'b0, '0, 8'h3C);
        idle(4);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 8'h3C);
        idle(6);

        // W(0x11), R, W(0x22): expect WRITE, TURN, READ, TURN, WRITE.
        do_reset();
        step(1'b1, 1'b1, 8'h11, 8'h5E);
        step(1'b1, 1'b0, '0, 8'h6B);
        step(1'b1, 1'b1, 8'h22, 8'h77);
        idle(8);

        // Alternating directions stall the queue on TURN cycles until it fills.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, i[0] == 1'b0, 8'(8'h30 + i), DW'($urandom));
        idle(30);

        // Reset asserted in the middle of a WRITE cycle.
        do_reset();
        step(1'b1, 1'b1, 8'h5A, 8'h00);
        idle(1);
        check_bit("pre_reset_write", en_write, 1'b1);
        do_reset();
        idle(3);

        // Write, three idle cycles, then read: TURN must still precede the READ.
        step(1'b1, 1'b1, 8'h42, 8'h00);
        idle(3);
        step(1'b1, 1'b0, '0, 8'h99);
        idle(5);

        // Randomized traffic with bursts and gaps.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom_range(0, 254)), DW'($urandom));
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
